// File: rtl/md_ctrl_pkg.sv
// Shared encodings for the HI/LO issue controller and the multiply-divide unit.
package md_ctrl_pkg;

    localparam int MUL_LAT_DEF = 5;
    localparam int DIV_LAT_DEF = 10;

    localparam logic [2:0] MD_MULT  = 3'b000;
    localparam logic [2:0] MD_MULTU = 3'b001;
    localparam logic [2:0] MD_DIV   = 3'b010;
    localparam logic [2:0] MD_DIVU  = 3'b011;
    localparam logic [2:0] MD_MTHI  = 3'b100;
    localparam logic [2:0] MD_MTLO  = 3'b101;
    localparam logic [2:0] MD_IDLE  = 3'b111;

    localparam logic [3:0] CLS_NONE  = 4'd0;
    localparam logic [3:0] CLS_MULT  = 4'd1;
    localparam logic [3:0] CLS_MULTU = 4'd2;
    localparam logic [3:0] CLS_DIV   = 4'd3;
    localparam logic [3:0] CLS_DIVU  = 4'd4;
    localparam logic [3:0] CLS_MTHI  = 4'd5;
    localparam logic [3:0] CLS_MTLO  = 4'd6;
    localparam logic [3:0] CLS_MFHI  = 4'd7;
    localparam logic [3:0] CLS_MFLO  = 4'd8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_t;

endpackage

// File: rtl/md_lat_counter.sv
// Loadable down-counter that shadows the multiply-divide unit's remaining latency.
module md_lat_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] cnt,
    output logic             zero
);

    assign zero = (cnt == '0);

    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (!zero)
            cnt <= cnt - 1'b1;
    end

endmodule

// File: rtl/md_ctrl.sv
// E-stage HI/LO issue and hazard controller: starts the multiply-divide unit,
// stalls D-stage HI/LO users while it runs, and cross-checks the unit's busy.
module md_ctrl
    import md_ctrl_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF,
    parameter int CNT_W   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        e_valid,
    input  logic [3:0]  e_mdclass,
    input  logic        d_uses_md,
    input  logic        flush,
    input  logic        md_busy,
    output logic        start,
    output logic [2:0]  md_op,
    output logic        stall_d,
    output logic        hilo_sel,
    output logic        sync_err,
    output logic [31:0] stall_cnt
);

    md_state_t        state;
    logic             issue;
    logic             is_arith;
    logic             run;
    logic [CNT_W-1:0] load_val;
    logic [CNT_W-1:0] cnt;
    logic             cnt_zero;

    always_comb begin
        issue    = e_valid & ~flush;
        is_arith = (e_mdclass >= CLS_MULT) && (e_mdclass <= CLS_DIVU);
        run      = (state == ST_RUN);
        start    = issue & is_arith & ~run;
        stall_d  = d_uses_md & (start | run);
        hilo_sel = (e_mdclass == CLS_MFLO);
        load_val = (e_mdclass == CLS_MULT || e_mdclass == CLS_MULTU)
                   ? CNT_W'(MUL_LAT) : CNT_W'(DIV_LAT);
        md_op    = MD_IDLE;
        if (issue) begin
            case (e_mdclass)
                CLS_MULT:  md_op = MD_MULT;
                CLS_MULTU: md_op = MD_MULTU;
                CLS_DIV:   md_op = MD_DIV;
                CLS_DIVU:  md_op = MD_DIVU;
                CLS_MTHI:  md_op = MD_MTHI;
                CLS_MTLO:  md_op = MD_MTLO;
                default:   md_op = MD_IDLE;
            endcase
        end
    end

    md_lat_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (start),
        .load_val (load_val),
        .cnt      (cnt),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            sync_err  <= 1'b0;
            stall_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: if (start) state <= ST_RUN;
                ST_RUN:  if (cnt == CNT_W'(1)) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
            // Any disagreement with the unit, an arithmetic op slipping past the
            // stall, or the FSM drifting from its own countdown is sticky.
            if ((md_busy != (start | run)) || (issue & is_arith & run) || (run == cnt_zero))
                sync_err <= 1'b1;
            if (stall_d)
                stall_cnt <= stall_cnt + 32'd1;
        end
    end

endmodule

// File: doc/md_ctrl.md
Name: md_ctrl

Overview:
- E-stage issue/hazard controller that sits directly upstream of the HI/LO multiply-divide unit.
- Decodes the E-stage HI/LO operation class and drives the unit's start pulse and md_op code.
- Tracks the unit's latency with its own shadow countdown and raises a D-stage stall for any HI/LO-using instruction while an operation is in flight.
- Cancels issue on pipeline flush, cross-checks its shadow countdown against the unit's busy output, and counts stall cycles.

Parameters:
- MUL_LAT, 5, cycles the unit stays busy after the start cycle for mult/multu.
- DIV_LAT, 10, cycles the unit stays busy after the start cycle for div/divu.
- CNT_W, 4, width of the shadow countdown; must hold max(MUL_LAT, DIV_LAT).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- e_valid  in  1  E-stage instruction is valid and not a bubble
- e_mdclass  in  4  E-stage HI/LO class: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo, 9–15 illegal (treated as none)
- d_uses_md  in  1  D-stage instruction is any of classes 1–8
- flush  in  1  exception/eret flush of the E stage this cycle
- md_busy  in  1  busy output of the multiply-divide unit
- start  out  1  start pulse to the unit
- md_op  out  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 111 idle
- stall_d  out  1  freeze PC/IF/D, insert bubble into E
- hilo_sel  out  1  E-stage result mux: 0 = hi, 1 = lo; valid when class is 7 or 8
- sync_err  out  1  sticky: shadow state disagreed with md_busy
- stall_cnt  out  32  number of cycles stall_d was high, wraps

Behaviour:
- Reset values: state IDLE, countdown 0, sync_err 0, stall_cnt 0. This gives start 0, md_op 111, stall_d 0, hilo_sel 0.
- Define issue = e_valid & ~flush.

Combinational outputs:
- start = issue & class∈{1..4} & state==IDLE.
- md_op = class-mapped code when issue & class∈{1..6}; otherwise 111. The unit acts on 100/101 whenever start=0, so md_op must be 111 at all other times.
- hilo_sel = (class==8).
- stall_d = d_uses_md & (start | state==RUN).

FSM:
- IDLE: on start, load countdown with MUL_LAT (classes 1, 2) or DIV_LAT (classes 3, 4), then go to RUN.
- RUN: decrement each cycle. When countdown==1, return to IDLE at the next edge (countdown 0).
- Timing: start at cycle T, stall_d possible T..T+LAT, and a D-stage md instruction reaches E at T+LAT+1. This is exactly when the unit drops busy.

Boundary conditions:
- Flush in the start cycle: start suppressed, no state change.
- Flush during RUN: the operation completes; the countdown is unaffected.
- Class 1–4 arriving in E while in RUN: impossible given stall_d. If it occurs anyway, start stays 0 and sync_err is set.
- sync_err sets when md_busy != (start | state==RUN) in any cycle. It clears only on reset.
- Reset mid-operation: returns to IDLE immediately, countdown 0. The unit is reset by the same signal.
- stall_cnt increments by 1 on every cycle with stall_d=1 and wraps from 0xFFFFFFFF to 0.
- Classes 9–15 behave as class 0.

Decomposition:
- Shared package: md_op encodings (MD_MULT..MD_MTLO, MD_IDLE=3'b111), e_mdclass encodings, FSM state constants.
- Shared package: latency defaults for MUL_LAT and DIV_LAT, shared with the unit.
- One natural sub-module, md_lat_counter: loadable down-counter with load value, load enable, and zero flag.

Test Plan:
- Reset, then mult with D-stage mflo following → start high one cycle, md_op 000, stall_d high 6 cycles (T..T+5), stall_cnt=6, sync_err 0.
- divu with D-stage mfhi → md_op 011, stall_d 11 cycles; mfhi reaches E at T+11 with hilo_sel 0, md_busy 0.
- mult with flush asserted the same cycle → start 0, md_op 111, state IDLE, stall_d 0 even with d_uses_md=1.
- div issued, flush at T+3 → countdown continues, stall_d held until T+10, sync_err 0.
- mthi with no busy → start 0, md_op 100 for one cycle, no stall; mtlo next cycle → md_op 101.
- Force md_busy=1 while IDLE → sync_err sets and stays set; reset asserted at T+2 of a div → all outputs return to reset values next cycle.
